// File: rtl/pl_pkg.sv
// pl_pkg: shared types and constants for the program loader.
// Holds the token mnemonic enum, instruction opcodes, field widths and FSM states.
// The optional operand range check is enabled with `define PL_OPERAND_CHECK_EN.
package pl_pkg;

  localparam int INSTR_W   = 9;
  localparam int PC_W      = 10;
  localparam int LUT_IDX_W = 4;
  localparam int OP_W      = 5;
  localparam int REG_W     = 3;
  localparam int IMM_W     = 4;

  // Token mnemonics; codes above OP_LABEL are unknown and rejected.
  typedef enum logic [OP_W-1:0] {
    OP_CMP   = 5'd0,
    OP_MOV   = 5'd1,
    OP_ADD   = 5'd2,
    OP_SUB   = 5'd3,
    OP_LSL   = 5'd4,
    OP_ROL   = 5'd5,
    OP_AND   = 5'd6,
    OP_OR    = 5'd7,
    OP_XOR   = 5'd8,
    OP_JGE   = 5'd9,
    OP_JG    = 5'd10,
    OP_JMP   = 5'd11,
    OP_JGM   = 5'd12,
    OP_INC   = 5'd13,
    OP_LSLI  = 5'd14,
    OP_ROLI  = 5'd15,
    OP_CLR   = 5'd16,
    OP_NOT   = 5'd17,
    OP_LSR   = 5'd18,
    OP_LDR   = 5'd19,
    OP_STR   = 5'd20,
    OP_LDI   = 5'd21,
    OP_STI   = 5'd22,
    OP_LABEL = 5'd23
  } pl_op_e;

  // 3-bit opcodes: two full 3-bit register fields follow.
  localparam logic [2:0] OPC_CMP  = 3'b000;
  localparam logic [2:0] OPC_MOV  = 3'b001;

  // 5-bit ALU opcodes: two truncated 2-bit register fields follow.
  localparam logic [4:0] OPC_ADD  = 5'b01000;
  localparam logic [4:0] OPC_SUB  = 5'b01001;
  localparam logic [4:0] OPC_LSL  = 5'b01010;
  localparam logic [4:0] OPC_ROL  = 5'b01011;
  localparam logic [4:0] OPC_AND  = 5'b01100;
  localparam logic [4:0] OPC_OR   = 5'b01101;
  localparam logic [4:0] OPC_XOR  = 5'b01110;

  // 5-bit jump opcodes: a 4-bit label id follows.
  localparam logic [4:0] OPC_JGE  = 5'b10000;
  localparam logic [4:0] OPC_JG   = 5'b10001;
  localparam logic [4:0] OPC_JMP  = 5'b10010;
  localparam logic [4:0] OPC_JGM  = 5'b10011;

  // 6-bit immediate opcodes: a 3-bit immediate follows.
  localparam logic [5:0] OPC_INC  = 6'b101000;
  localparam logic [5:0] OPC_LSLI = 6'b101001;
  localparam logic [5:0] OPC_ROLI = 6'b101010;
  localparam logic [5:0] OPC_CLR  = 6'b101011;
  localparam logic [5:0] OPC_NOT  = 6'b101100;
  localparam logic [5:0] OPC_LSR  = 6'b101101;
  localparam logic [5:0] OPC_LDR  = 6'b101110;
  localparam logic [5:0] OPC_STR  = 6'b101111;
  localparam logic [5:0] OPC_LDI  = 6'b110000;
  localparam logic [5:0] OPC_STI  = 6'b110001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } pl_state_e;

  // Mnemonics whose register operands are packed into 2-bit fields.
  function automatic logic is_reg2_op(input logic [OP_W-1:0] op);
    return (op >= OP_ADD) && (op <= OP_XOR);
  endfunction

  // Mnemonics whose immediate is packed into a 3-bit field.
  function automatic logic is_imm3_op(input logic [OP_W-1:0] op);
    return (op >= OP_INC) && (op <= OP_STI);
  endfunction

endpackage

// File: rtl/instr_encoder.sv
// instr_encoder: combinational token-to-instruction-word translation.
// Flags LABEL tokens and unknown mnemonics; with PL_OPERAND_CHECK_EN defined it
// also flags operands that would not fit their encoded field.
module instr_encoder
  import pl_pkg::*;
(
  input  logic [OP_W-1:0]    op,
  input  logic [REG_W-1:0]   ra,
  input  logic [REG_W-1:0]   rb,
  input  logic [IMM_W-1:0]   imm,
  output logic [INSTR_W-1:0] word,
  output logic               is_label,
  output logic               illegal
);

  // Field packing per mnemonic group; opcode always sits in the msbs.
  always_comb begin
    word     = '0;
    is_label = 1'b0;
    illegal  = 1'b0;
    case (op)
      OP_CMP:  word = {OPC_CMP, ra, rb};
      OP_MOV:  word = {OPC_MOV, ra, rb};
      OP_ADD:  word = {OPC_ADD, ra[1:0], rb[1:0]};
      OP_SUB:  word = {OPC_SUB, ra[1:0], rb[1:0]};
      OP_LSL:  word = {OPC_LSL, ra[1:0], rb[1:0]};
      OP_ROL:  word = {OPC_ROL, ra[1:0], rb[1:0]};
      OP_AND:  word = {OPC_AND, ra[1:0], rb[1:0]};
      OP_OR:   word = {OPC_OR,  ra[1:0], rb[1:0]};
      OP_XOR:  word = {OPC_XOR, ra[1:0], rb[1:0]};
      OP_JGE:  word = {OPC_JGE, imm};
      OP_JG:   word = {OPC_JG,  imm};
      OP_JMP:  word = {OPC_JMP, imm};
      OP_JGM:  word = {OPC_JGM, imm};
      OP_INC:  word = {OPC_INC,  imm[2:0]};
      OP_LSLI: word = {OPC_LSLI, imm[2:0]};
      OP_ROLI: word = {OPC_ROLI, imm[2:0]};
      OP_CLR:  word = {OPC_CLR,  imm[2:0]};
      OP_NOT:  word = {OPC_NOT,  imm[2:0]};
      OP_LSR:  word = {OPC_LSR,  imm[2:0]};
      OP_LDR:  word = {OPC_LDR,  imm[2:0]};
      OP_STR:  word = {OPC_STR,  imm[2:0]};
      OP_LDI:  word = {OPC_LDI,  imm[2:0]};
      OP_STI:  word = {OPC_STI,  imm[2:0]};
      OP_LABEL: is_label = 1'b1;
      default: illegal = 1'b1;
    endcase
`ifdef PL_OPERAND_CHECK_EN
    // Reject operands that the narrow fields would silently truncate.
    if (is_reg2_op(op) && (ra[2] || rb[2])) illegal = 1'b1;
    if (is_imm3_op(op) && imm[3])           illegal = 1'b1;
`endif
  end

endmodule

// File: rtl/prog_loader.sv
// prog_loader: streams mnemonic tokens into instruction memory and label ids
// into the jump LUT. Optional operand range checking: PL_OPERAND_CHECK_EN.
module prog_loader
  import pl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OP_W-1:0]      in_op,
  input  logic [REG_W-1:0]     in_ra,
  input  logic [REG_W-1:0]     in_rb,
  input  logic [IMM_W-1:0]     in_imm,
  input  logic                 in_last,
  output logic                 im_wr_en,
  output logic [PC_W-1:0]      im_addr,
  output logic [INSTR_W-1:0]   im_wdata,
  output logic                 lut_wr_en,
  output logic [LUT_IDX_W-1:0] lut_addr,
  output logic [PC_W-1:0]      lut_wdata,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  pl_state_e            state, next_state;
  // Extra msb marks "memory full": set once the instruction at 1023 is written.
  logic [PC_W:0]        pc;
  logic                 accept;
  logic                 overflow;
  logic                 tok_err;
  logic [INSTR_W-1:0]   enc_word;
  logic                 enc_label;
  logic                 enc_illegal;

  instr_encoder u_enc (
    .op       (in_op),
    .ra       (in_ra),
    .rb       (in_rb),
    .imm      (in_imm),
    .word     (enc_word),
    .is_label (enc_label),
    .illegal  (enc_illegal)
  );

  assign accept   = in_valid && in_ready;
  // Labels never consume a slot, so only real instructions can overflow.
  assign overflow = !enc_label && pc[PC_W];
  assign tok_err  = enc_illegal || overflow;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state and status outputs; start is ignored while loading.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    case (state)
      ST_IDLE: if (start) next_state = ST_LOAD;
      ST_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (accept) begin
          if (tok_err)      next_state = ST_ERR;
          else if (in_last) next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) next_state = ST_LOAD;
      end
      ST_ERR: begin
        err = 1'b1;
        if (start) next_state = ST_LOAD;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // PC and registered write ports; write enables are single-cycle pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= '0;
      im_wr_en  <= 1'b0;
      im_addr   <= '0;
      im_wdata  <= '0;
      lut_wr_en <= 1'b0;
      lut_addr  <= '0;
      lut_wdata <= '0;
    end else begin
      im_wr_en  <= 1'b0;
      lut_wr_en <= 1'b0;
      if (state != ST_LOAD) begin
        if (start) pc <= '0;
      end else if (accept && !tok_err) begin
        if (enc_label) begin
          lut_wr_en <= 1'b1;
          lut_addr  <= in_imm;
          lut_wdata <= pc[PC_W-1:0];
        end else begin
          im_wr_en  <= 1'b1;
          im_addr   <= pc[PC_W-1:0];
          im_wdata  <= enc_word;
          pc        <= pc + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed and randomized token sessions checked against a
// behavioural model of the loader (write logs compared after each session).
module tb_prog_loader;
  import pl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [4:0] in_op = '0;
  logic [2:0] in_ra = '0;
  logic [2:0] in_rb = '0;
  logic [3:0] in_imm = '0;
  logic       in_last = 1'b0;
  logic       im_wr_en;
  logic [9:0] im_addr;
  logic [8:0] im_wdata;
  logic       lut_wr_en;
  logic [3:0] lut_addr;
  logic [9:0] lut_wdata;
  logic       busy, done, err;

  prog_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_ra(in_ra), .in_rb(in_rb), .in_imm(in_imm), .in_last(in_last),
    .im_wr_en(im_wr_en), .im_addr(im_addr), .im_wdata(im_wdata),
    .lut_wr_en(lut_wr_en), .lut_addr(lut_addr), .lut_wdata(lut_wdata),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Observed write log, sampled mid-cycle.
  int o_im_a[$], o_im_d[$], o_lut_a[$], o_lut_d[$];
  int both_cnt = 0;
  always @(negedge clk) begin
    if (im_wr_en)  begin o_im_a.push_back(int'(im_addr));   o_im_d.push_back(int'(im_wdata));  end
    if (lut_wr_en) begin o_lut_a.push_back(int'(lut_addr)); o_lut_d.push_back(int'(lut_wdata)); end
    if (im_wr_en && lut_wr_en) both_cnt++;
  end

  // Model: session status 0 idle, 1 loading, 2 done, 3 error; pc counts written words.
  int m_st = 0;
  int m_pc = 0;
  int e_im_a[$], e_im_d[$], e_lut_a[$], e_lut_d[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Instruction word from the field layout: opcode in msbs, operands below.
  function automatic int m_enc(input int op, input int ra, input int rb, input int imm);
    int r2 = ((ra % 4) * 4) + (rb % 4);
    int i3 = imm % 8;
    case (op)
      0:  return (0 * 64) + (ra * 8) + rb;
      1:  return (1 * 64) + (ra * 8) + rb;
      2:  return (8  * 16) + r2;
      3:  return (9  * 16) + r2;
      4:  return (10 * 16) + r2;
      5:  return (11 * 16) + r2;
      6:  return (12 * 16) + r2;
      7:  return (13 * 16) + r2;
      8:  return (14 * 16) + r2;
      9:  return (16 * 16) + imm;
      10: return (17 * 16) + imm;
      11: return (18 * 16) + imm;
      12: return (19 * 16) + imm;
      default: return (op < 23) ? ((40 + op - 13) * 8 + i3) : 0;
    endcase
  endfunction

  function automatic bit m_illegal(input int op, input int ra, input int rb, input int imm);
    if (op > 23) return 1'b1;
`ifdef PL_OPERAND_CHECK_EN
    if (op >= 2 && op <= 8 && (ra > 3 || rb > 3)) return 1'b1;
    if (op >= 13 && op <= 22 && imm > 7) return 1'b1;
`endif
    return 1'b0;
  endfunction

  task automatic m_apply(input int op, input int ra, input int rb, input int imm, input bit last);
    if (m_illegal(op, ra, rb, imm)) m_st = 3;
    else if (op == 23) begin
      e_lut_a.push_back(imm); e_lut_d.push_back(m_pc % 1024);
      if (last) m_st = 2;
    end else if (m_pc >= 1024) m_st = 3;
    else begin
      e_im_a.push_back(m_pc); e_im_d.push_back(m_enc(op, ra, rb, imm));
      m_pc++;
      if (last) m_st = 2;
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (m_st != 1) begin m_st = 1; m_pc = 0; end
  endtask

  task automatic send(input logic [4:0] op, input logic [2:0] ra, input logic [2:0] rb,
                      input logic [3:0] imm, input bit last);
    int n = 0;
    in_valid = 1'b1; in_op = op; in_ra = ra; in_rb = rb; in_imm = imm; in_last = last;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin
      chk("ready_timeout", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b0; in_last = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    m_apply(int'(op), int'(ra), int'(rb), int'(imm), last);
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_busy"},  {31'd0, busy},     {31'd0, m_st == 1});
    chk({tag, "_done"},  {31'd0, done},     {31'd0, m_st == 2});
    chk({tag, "_err"},   {31'd0, err},      {31'd0, m_st == 3});
    chk({tag, "_ready"}, {31'd0, in_ready}, {31'd0, m_st == 1});
  endtask

  // Let the last pulse be logged, then compare and clear both logs.
  task automatic check_logs(input string tag);
    int bad = 0;
    @(posedge clk); #1;
    chk({tag, "_im_count"}, o_im_a.size(), e_im_a.size());
    chk({tag, "_lut_count"}, o_lut_a.size(), e_lut_a.size());
    if (o_im_a.size() == e_im_a.size())
      foreach (e_im_a[i]) if (o_im_a[i] != e_im_a[i] || o_im_d[i] != e_im_d[i]) begin
        if (bad == 0) $display("first im diff %s idx %0d addr %0h/%0h data %0h/%0h",
                               tag, i, o_im_a[i], e_im_a[i], o_im_d[i], e_im_d[i]);
        bad++;
      end
    if (o_lut_a.size() == e_lut_a.size())
      foreach (e_lut_a[i]) if (o_lut_a[i] != e_lut_a[i] || o_lut_d[i] != e_lut_d[i]) bad++;
    chk({tag, "_content_diffs"}, bad, 0);
    chk({tag, "_both_pulses"}, both_cnt, 0);
    o_im_a.delete(); o_im_d.delete(); o_lut_a.delete(); o_lut_d.delete();
    e_im_a.delete(); e_im_d.delete(); e_lut_a.delete(); e_lut_d.delete();
  endtask

  initial begin
    // Reset values.
    #1;
    chk("rst_im_wr_en", {31'd0, im_wr_en}, 0);
    chk("rst_lut_wr_en", {31'd0, lut_wr_en}, 0);
    check_state("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_no_pulse", {31'd0, im_wr_en | lut_wr_en}, 0);
    check_state("post_rst");

    // Single add, last.
    do_start();
    check_state("s1_load");
    send(5'(OP_ADD), 3'd1, 3'd2, 4'd0, 1'b1);
    chk("s1_im_data", {23'd0, im_wdata}, 32'h086);
    chk("s1_im_addr", {22'd0, im_addr}, 0);
    check_logs("s1");
    check_state("s1_end");

    // Known encodings, then a label at pc 3 and a following word at pc 3.
    do_start();
    send(5'(OP_JMP), 3'd0, 3'd0, 4'hA, 1'b0);
    chk("s3_jmp", {23'd0, im_wdata}, 32'h12A);
    send(5'(OP_STI), 3'd0, 3'd0, 4'd6, 1'b0);
    chk("s3_sti", {23'd0, im_wdata}, 32'h18E);
    send(5'(OP_CMP), 3'd7, 3'd0, 4'd0, 1'b0);
    chk("s3_cmp", {23'd0, im_wdata}, 32'h038);
    send(5'(OP_LABEL), 3'd0, 3'd0, 4'd5, 1'b0);
    chk("s2_lut_en", {31'd0, lut_wr_en}, 1);
    chk("s2_no_im", {31'd0, im_wr_en}, 0);
    chk("s2_lut_addr", {28'd0, lut_addr}, 5);
    chk("s2_lut_data", {22'd0, lut_wdata}, 3);
    send(5'(OP_MOV), 3'd2, 3'd5, 4'd0, 1'b1);
    chk("s2_pc_kept", {22'd0, im_addr}, 3);
    check_logs("s23");
    check_state("s23_end");

    // start while loading is ignored.
    do_start();
    send(5'(OP_SUB), 3'd3, 3'd1, 4'd0, 1'b0);
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    send(5'(OP_INC), 3'd0, 3'd0, 4'd3, 1'b1);
    check_logs("start_ign");
    check_state("start_ign");

    // Unknown mnemonic.
    do_start();
    send(5'd28, 3'd1, 3'd1, 4'd1, 1'b0);
    check_logs("unknown");
    check_state("unknown");

    // Narrow-field operand out of range.
    do_start();
    send(5'(OP_XOR), 3'd4, 3'd1, 4'd0, 1'b1);
    check_logs("xor_ra4");
    check_state("xor_ra4");

    // Randomized sessions.
    for (int s = 0; s < 4; s++) begin
      do_start();
      for (int i = 0; i < 30 && m_st == 1; i++)
        send(5'($urandom_range(0, 23)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
             4'($urandom_range(0, 15)), i == 29);
      check_logs("rand");
      check_state("rand");
    end

    // Fill memory: 1025 back-to-back instructions.
    do_start();
    for (int i = 0; i < 1025; i++) send(5'(OP_INC), 3'd0, 3'd0, 4'(i % 8), 1'b0);
    check_logs("ovf");
    check_state("ovf");

    // Reset while a write pulse is pending.
    do_start();
    in_valid = 1'b1; in_op = 5'(OP_INC); in_imm = 4'd1; in_last = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0; in_valid = 1'b0;
    m_st = 0; m_pc = 0;
    #1;
    chk("s5_im_wr_en", {31'd0, im_wr_en}, 0);
    chk("s5_im_addr", {22'd0, im_addr}, 0);
    chk("s5_im_wdata", {23'd0, im_wdata}, 0);
    chk("s5_lut", {31'd0, lut_wr_en}, 0);
    check_state("s5");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("s5_no_pulse", {31'd0, im_wr_en | lut_wr_en}, 0);
    check_logs("s5");
    check_state("s5_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
